aes_sub_bytes_pipe: RTL and testbench

// - Parametrised, pipelined SubBytes/InvSubBytes unit for the AES datapath.
// - Substitutes LANES bytes per transfer, forward or inverse S-box selected per transfer.
// - Valid/ready on both sides; sits between AddRoundKey and ShiftRows in the round engine.
// - Counts completed transfers for round-control bookkeeping.

---
 rtl/aes_pkg.sv | 57 +++++
 rtl/aes_sbox_lane.sv | 15 +
 rtl/aes_sub_bytes_pipe.sv | 108 ++++++++++
 tb/tb_aes_sub_bytes_pipe.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES constants and the FIPS-197 forward/inverse S-box lookups.
package aes_pkg;

    localparam int BYTE_W = 8;

    localparam logic MODE_FWD = 1'b0;
    localparam logic MODE_INV = 1'b1;

    localparam logic [0:255][7:0] SBOX_TBL = {
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam logic [0:255][7:0] INV_SBOX_TBL = {
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    // Forward SubBytes substitution of a single byte.
    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TBL[b];
    endfunction

    // InvSubBytes substitution of a single byte.
    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return INV_SBOX_TBL[b];
    endfunction

endpackage

// File: rtl/aes_sbox_lane.sv
// One byte lane of the substitution stage: forward or inverse S-box by mode.
module aes_sbox_lane
    import aes_pkg::*;
(
    input  logic       mode,
    input  logic [7:0] din,
    output logic [7:0] dout
);

    // Pure table lookup; the mode bit chooses which table drives the lane.
    always_comb begin
        dout = (mode == MODE_INV) ? inv_sbox(din) : sbox(din);
    end

endmodule

// File: rtl/aes_sub_bytes_pipe.sv
// Two-stage valid/ready SubBytes/InvSubBytes pipeline with a transfer counter.
// S1 holds the raw transfer, the lookup sits between S1 and S2, S2 drives out_*.
module aes_sub_bytes_pipe
    import aes_pkg::*;
#(
    parameter int LANES = 16,
    parameter int CNT_W = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_mode,
    input  logic [BYTE_W*LANES-1:0] in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_mode,
    output logic [BYTE_W*LANES-1:0] out_data,
    output logic [CNT_W-1:0]        xfer_cnt
);

    logic                    s1_valid_q, s1_valid_d;
    logic                    s1_mode_q,  s1_mode_d;
    logic [BYTE_W*LANES-1:0] s1_data_q,  s1_data_d;
    logic                    s2_valid_q, s2_valid_d;
    logic                    s2_mode_q,  s2_mode_d;
    logic [BYTE_W*LANES-1:0] s2_data_q,  s2_data_d;
    logic [CNT_W-1:0]        cnt_q,      cnt_d;
    logic [BYTE_W*LANES-1:0] lane_out;
    logic                    s1_en;
    logic                    s2_en;

    // A stage may load when it is empty or the stage after it is moving;
    // input readiness follows the output side with no buffering in between.
    always_comb begin
        s2_en    = !s2_valid_q || out_ready;
        s1_en    = !s1_valid_q || s2_en;
        in_ready = s1_en;
    end

    // Independent per-lane lookups, all sharing the mode of the S1 transfer.
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        aes_sbox_lane u_lane (
            .mode (s1_mode_q),
            .din  (s1_data_q[BYTE_W*i +: BYTE_W]),
            .dout (lane_out[BYTE_W*i +: BYTE_W])
        );
    end

    // Next-state: data registers only load when a real transfer arrives,
    // valids follow their upstream stage whenever the stage is enabled.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_mode_d  = s1_mode_q;
        s1_data_d  = s1_data_q;
        s2_valid_d = s2_valid_q;
        s2_mode_d  = s2_mode_q;
        s2_data_d  = s2_data_q;
        cnt_d      = cnt_q;
        if (s1_en) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_mode_d = in_mode;
                s1_data_d = in_data;
            end
        end
        if (s2_en) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_mode_d = s1_mode_q;
                s2_data_d = lane_out;
            end
        end
        if (s2_valid_q && out_ready) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Stage and counter registers; reset discards anything in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_mode_q  <= 1'b0;
            s1_data_q  <= '0;
            s2_valid_q <= 1'b0;
            s2_mode_q  <= 1'b0;
            s2_data_q  <= '0;
            cnt_q      <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_mode_q  <= s1_mode_d;
            s1_data_q  <= s1_data_d;
            s2_valid_q <= s2_valid_d;
            s2_mode_q  <= s2_mode_d;
            s2_data_q  <= s2_data_d;
            cnt_q      <= cnt_d;
        end
    end

    // Output side is simply the S2 register contents.
    always_comb begin
        out_valid = s2_valid_q;
        out_mode  = s2_mode_q;
        out_data  = s2_data_q;
        xfer_cnt  = cnt_q;
    end

endmodule

// File: tb/tb_aes_sub_bytes_pipe.sv
// Self-checking bench for aes_sub_bytes_pipe (LANES=16, CNT_W=2).
module tb_aes_sub_bytes_pipe;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic         in_mode;
    logic [127:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic         out_mode;
    logic [127:0] out_data;
    logic [1:0]   xfer_cnt;

    int checks;
    int failures;
    int modelCnt;

    typedef struct {
        logic         mode;
        logic [127:0] din;
        logic [127:0] dout;
    } vec_t;

    vec_t vecs[7];

    typedef struct {
        logic         mode;
        logic [127:0] data;
    } exp_t;

    exp_t sb[$];

    aes_sub_bytes_pipe #(.LANES(16), .CNT_W(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mode   (in_mode),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_mode  (out_mode),
        .out_data  (out_data),
        .xfer_cnt  (xfer_cnt)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic m, input logic [127:0] d, input logic r);
        in_valid  = v;
        in_mode   = m;
        in_data   = d;
        out_ready = r;
        #1;
    endtask

    task automatic checkOutput(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Push one transfer through an otherwise idle pipe and return its result.
    task automatic runOne(input logic m, input logic [127:0] d, output logic [127:0] q);
        int n;
        applyStimulus(1'b1, m, d, 1'b1);
        n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        tick();
        applyStimulus(1'b0, 1'b0, '0, 1'b1);
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        checkOutput("rt_out_valid", 128'(out_valid), 128'(1));
        checkOutput("rt_mode", 128'(out_mode), 128'(m));
        q = out_data;
        tick();
        modelCnt++;
    endtask

    initial begin
        logic [127:0] din;
        logic [127:0] fw;
        logic [127:0] bk;
        int popped;
        int pushed;
        int cyc;
        logic iv;
        logic orr;
        int idx;
        exp_t e;

        checks   = 0;
        failures = 0;
        modelCnt = 0;

        vecs[0] = '{1'b0, {16{8'h00}}, {16{8'h63}}};
        vecs[1] = '{1'b0, {16{8'h53}}, {16{8'hED}}};
        vecs[2] = '{1'b1, 128'h0F0E0D0C0B0A09080706050403020100, 128'hFBD7F3819EA340BF38A53630D56A0952};
        vecs[3] = '{1'b0, {16{8'hFF}}, {16{8'h16}}};
        vecs[4] = '{1'b1, {16{8'hFF}}, {16{8'h7D}}};
        vecs[5] = '{1'b1, {16{8'h63}}, {16{8'h00}}};
        vecs[6] = '{1'b0, 128'h0F0E0D0C0B0A09080706050403020100, 128'h76ABD7FE2B670130C56F6BF27B777C63};

        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, '0, 1'b0);
        repeat (3) tick();
        checkOutput("rst_out_valid", 128'(out_valid), 128'(0));
        checkOutput("rst_out_data", out_data, '0);
        checkOutput("rst_out_mode", 128'(out_mode), 128'(0));
        checkOutput("rst_xfer_cnt", 128'(xfer_cnt), 128'(0));
        rst = 1'b0;
        #1;
        checkOutput("rst_in_ready", 128'(in_ready), 128'(1));

        // Directed vectors, one at a time, checking exact two-cycle latency.
        for (int i = 0; i < 7; i++) begin
            applyStimulus(1'b1, vecs[i].mode, vecs[i].din, 1'b1);
            checkOutput($sformatf("vec%0d_in_ready", i), 128'(in_ready), 128'(1));
            tick();
            applyStimulus(1'b0, 1'b0, '0, 1'b1);
            checkOutput($sformatf("vec%0d_early_valid", i), 128'(out_valid), 128'(0));
            tick();
            checkOutput($sformatf("vec%0d_valid", i), 128'(out_valid), 128'(1));
            checkOutput($sformatf("vec%0d_data", i), out_data, vecs[i].dout);
            checkOutput($sformatf("vec%0d_mode", i), 128'(out_mode), 128'(vecs[i].mode));
            tick();
            modelCnt++;
            checkOutput($sformatf("vec%0d_cnt", i), 128'(xfer_cnt), 128'(modelCnt & 3));
        end

        // Exhaustive round trip: forward then inverse, alternating per transfer.
        for (int k = 0; k < 16; k++) begin
            for (int i = 0; i < 16; i++) din[8*i +: 8] = 8'(16*k + i);
            runOne(1'b0, din, fw);
            runOne(1'b1, fw, bk);
            checkOutput($sformatf("roundtrip%0d", k), bk, din);
            if (k == 15) checkOutput("fwd_ff", 128'(fw[127:120]), 128'(8'h16));
        end
        checkOutput("rt_cnt", 128'(xfer_cnt), 128'(modelCnt & 3));

        // Stall: out_ready low for five cycles with three offers.
        applyStimulus(1'b1, 1'b0, vecs[0].din, 1'b0);
        checkOutput("stall_accept_a", 128'(in_ready), 128'(1));
        tick();
        applyStimulus(1'b1, 1'b0, vecs[1].din, 1'b0);
        checkOutput("stall_accept_b", 128'(in_ready), 128'(1));
        tick();
        for (int c = 0; c < 3; c++) begin
            applyStimulus(1'b1, 1'b1, vecs[2].din, 1'b0);
            checkOutput($sformatf("stall%0d_in_ready", c), 128'(in_ready), 128'(0));
            checkOutput($sformatf("stall%0d_valid", c), 128'(out_valid), 128'(1));
            checkOutput($sformatf("stall%0d_data", c), out_data, vecs[0].dout);
            tick();
        end
        applyStimulus(1'b1, 1'b1, vecs[2].din, 1'b1);
        checkOutput("release_in_ready", 128'(in_ready), 128'(1));
        checkOutput("drain_a", out_data, vecs[0].dout);
        tick();
        applyStimulus(1'b0, 1'b0, '0, 1'b1);
        checkOutput("drain_b_valid", 128'(out_valid), 128'(1));
        checkOutput("drain_b", out_data, vecs[1].dout);
        tick();
        checkOutput("drain_c_valid", 128'(out_valid), 128'(1));
        checkOutput("drain_c", out_data, vecs[2].dout);
        checkOutput("drain_c_mode", 128'(out_mode), 128'(1));
        tick();
        checkOutput("drain_empty", 128'(out_valid), 128'(0));
        modelCnt += 3;
        checkOutput("drain_cnt", 128'(xfer_cnt), 128'(modelCnt & 3));

        // Random handshake traffic against a scoreboard, ten transfers.
        popped = 0;
        pushed = 0;
        cyc    = 0;
        while (popped < 10 && cyc < 400) begin
            iv  = (pushed < 10) ? 1'($urandom_range(0, 1)) : 1'b0;
            orr = 1'($urandom_range(0, 1));
            idx = $urandom_range(0, 6);
            applyStimulus(iv, vecs[idx].mode, vecs[idx].din, orr);
            if (out_valid && orr) begin
                if (sb.size() == 0) begin
                    checkOutput("rnd_unexpected_out", 128'(out_valid), 128'(0));
                end else begin
                    e = sb.pop_front();
                    checkOutput("rnd_data", out_data, e.data);
                    checkOutput("rnd_mode", 128'(out_mode), 128'(e.mode));
                end
                popped++;
                modelCnt++;
            end
            if (iv && in_ready) begin
                sb.push_back('{vecs[idx].mode, vecs[idx].dout});
                pushed++;
            end
            tick();
            checkOutput("rnd_cnt", 128'(xfer_cnt), 128'(modelCnt & 3));
            cyc++;
        end
        checkOutput("rnd_all_drained", 128'(popped), 128'(10));

        // Reset with both stages full and a simultaneous handshake offered.
        applyStimulus(1'b1, 1'b0, vecs[0].din, 1'b0);
        tick();
        applyStimulus(1'b1, 1'b0, vecs[1].din, 1'b0);
        tick();
        checkOutput("full_in_ready", 128'(in_ready), 128'(0));
        checkOutput("full_out_valid", 128'(out_valid), 128'(1));
        rst = 1'b1;
        applyStimulus(1'b1, 1'b1, vecs[2].din, 1'b1);
        tick();
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, '0, 1'b1);
        modelCnt = 0;
        checkOutput("midrst_out_valid", 128'(out_valid), 128'(0));
        checkOutput("midrst_xfer_cnt", 128'(xfer_cnt), 128'(0));
        checkOutput("midrst_in_ready", 128'(in_ready), 128'(1));
        checkOutput("midrst_out_data", out_data, '0);
        tick();
        checkOutput("midrst_discard1", 128'(out_valid), 128'(0));
        tick();
        checkOutput("midrst_discard2", 128'(out_valid), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
